sprite_blit_engine: RTL

Copy engine that reads a sprite image out of a synchronous sprite ROM (registered read, one-cycle latency, 19-bit address, 5-bit palette index) and writes it into the frame buffer at a requested screen position. It sits between game logic, which issues draw requests, and the frame-buffer write port. It also handles transparency, horizontal mirroring (one ROM serves left- and right-facing frames) and screen-edge clipping.

---
 rtl/sprite_pkg.sv | 23 ++
 rtl/blit_addr_gen.sv | 75 +++++++
 rtl/sprite_blit_engine.sv | 117 +++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared types and default geometry for the sprite blit engine.
package sprite_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int unsigned DEF_SPR_W = 28;
    localparam int unsigned DEF_SPR_H = 42;
    localparam int unsigned DEF_FB_W  = 640;
    localparam int unsigned DEF_FB_H  = 480;

    localparam int unsigned ADDR_W = 19;
    localparam int unsigned PIX_W  = 5;
    localparam int unsigned POS_W  = 10;
    localparam int unsigned SCR_W  = 11;

    localparam logic [PIX_W-1:0] DEF_KEY = 5'h00;

endpackage

// File: rtl/blit_addr_gen.sv
// Walks the sprite in screen order and issues the (optionally mirrored) ROM read address.
module blit_addr_gen
    import sprite_pkg::*;
#(
    parameter int unsigned SPR_W = DEF_SPR_W,
    parameter int unsigned SPR_H = DEF_SPR_H,
    localparam int unsigned COL_W = $clog2(SPR_W),
    localparam int unsigned ROW_W = $clog2(SPR_H)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              mirror_in,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [COL_W-1:0]  col,
    output logic [ROW_W-1:0]  row,
    output logic              valid,
    output logic              last_c
);

    logic [COL_W-1:0]  col_q, col_d, mcol_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic              valid_q, valid_d;
    logic              mirror_q, mirror_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;

    assign last_c = valid_q && (col_q == COL_W'(SPR_W - 1)) && (row_q == ROW_W'(SPR_H - 1));

    // Counters name the pixel being issued this cycle; the address is registered alongside.
    always_comb begin
        col_d    = col_q;
        row_d    = row_q;
        valid_d  = valid_q;
        mirror_d = mirror_q;
        if (load) begin
            col_d    = '0;
            row_d    = '0;
            valid_d  = 1'b1;
            mirror_d = mirror_in;
        end else if (last_c) begin
            valid_d = 1'b0;
        end else if (valid_q) begin
            if (col_q == COL_W'(SPR_W - 1)) begin
                col_d = '0;
                row_d = row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
        mcol_d     = mirror_d ? COL_W'(SPR_W - 1) - col_d : col_d;
        rom_addr_d = ADDR_W'(row_d) * ADDR_W'(SPR_W) + ADDR_W'(mcol_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q      <= '0;
            row_q      <= '0;
            valid_q    <= 1'b0;
            mirror_q   <= 1'b0;
            rom_addr_q <= '0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            valid_q    <= valid_d;
            mirror_q   <= mirror_d;
            rom_addr_q <= rom_addr_d;
        end
    end

    assign rom_addr = rom_addr_q;
    assign col      = col_q;
    assign row      = row_q;
    assign valid    = valid_q;

endmodule

// File: rtl/sprite_blit_engine.sv
// Copies a sprite from the sprite ROM into the frame buffer with transparency,
// horizontal mirroring and screen-edge clipping, one pixel per cycle.
module sprite_blit_engine
    import sprite_pkg::*;
#(
    parameter int unsigned      SPR_W = DEF_SPR_W,
    parameter int unsigned      SPR_H = DEF_SPR_H,
    parameter int unsigned      FB_W  = DEF_FB_W,
    parameter int unsigned      FB_H  = DEF_FB_H,
    parameter logic [PIX_W-1:0] KEY   = DEF_KEY
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [POS_W-1:0]  pos_x,
    input  logic [POS_W-1:0]  pos_y,
    input  logic              mirror,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [PIX_W-1:0]  rom_data,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [PIX_W-1:0]  fb_data
);

    localparam int unsigned COL_W = $clog2(SPR_W);
    localparam int unsigned ROW_W = $clog2(SPR_H);

    state_t            state_q, state_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              accept_c;
    logic [POS_W-1:0]  pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [COL_W-1:0]  gen_col;
    logic [ROW_W-1:0]  gen_row;
    logic              gen_valid, gen_last_c;
    logic [SCR_W-1:0]  sx_c, sy_c;
    logic              slot_q, slot_d;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;

    assign accept_c = (state_q == S_IDLE) && start;

    blit_addr_gen #(
        .SPR_W(SPR_W),
        .SPR_H(SPR_H)
    ) u_addr_gen (
        .clk      (Clk),
        .rst      (Reset),
        .load     (accept_c),
        .mirror_in(mirror),
        .rom_addr (rom_addr),
        .col      (gen_col),
        .row      (gen_row),
        .valid    (gen_valid),
        .last_c   (gen_last_c)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (gen_last_c) state_d = S_DRAIN;
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Status flags follow the state being entered so they line up with it.
    always_comb begin
        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    // Delay slot: screen position and clip decision ride beside the ROM read.
    always_comb begin
        pos_x_d   = accept_c ? pos_x : pos_x_q;
        pos_y_d   = accept_c ? pos_y : pos_y_q;
        sx_c      = SCR_W'(pos_x_q) + SCR_W'(gen_col);
        sy_c      = SCR_W'(pos_y_q) + SCR_W'(gen_row);
        slot_d    = gen_valid && (sx_c < SCR_W'(FB_W)) && (sy_c < SCR_W'(FB_H));
        fb_addr_d = ADDR_W'(32'(sy_c) * FB_W + 32'(sx_c));
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pos_x_q   <= '0;
            pos_y_q   <= '0;
            slot_q    <= 1'b0;
            fb_addr_q <= '0;
        end else begin
            busy_q    <= busy_d;
            done_q    <= done_d;
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            slot_q    <= slot_d;
            fb_addr_q <= fb_addr_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign fb_we   = slot_q && (rom_data != KEY);
    assign fb_addr = fb_addr_q;
    assign fb_data = slot_q ? rom_data : '0;

endmodule
